// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, state
// encoding, datapath select encodings and trap causes.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_TRAP     = 4'd11
  } state_e;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC  = 2'b10;
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath
// plus memory port (slave).
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] aluop;
  logic       reg_write;
  logic       mem_to_reg;
  logic       retire;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg,
           retire, trap, trap_cause, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg,
           retire, trap, trap_cause, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts stalled memory-request cycles and flags the cycle on which the
// request has been outstanding for MEM_TIMEOUT cycles without completion.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Idle or completed accesses hold the count at zero, so every new request starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || ready_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Wait-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = req_i && !ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB over a
// shared memory port and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] cause_q;
  logic [1:0] cause_d;
  logic       timeout_s;

  logic       mem_req_s;
  logic       mem_we_s;
  logic       iord_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       pc_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] aluop_s;
  logic       reg_write_s;
  logic       mem_to_reg_s;
  logic       retire_s;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (mem_req_s),
    .ready_i  (bus.mem_ready),
    .timeout_o(timeout_s)
  );

  // Next-state and trap-cause selection.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (bus.opcode)
          OP_R:              state_d = ST_EXEC_R;
          OP_I:              state_d = ST_EXEC_I;
          OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
          OP_BRANCH:         state_d = ST_BRANCH;
          default: begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
      ST_MEM_ADDR: begin
        if (bus.opcode == OP_LOAD) begin
          state_d = ST_MEM_RD;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_MEM_RD, ST_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
        end else if (timeout_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          state_d = state_q;
        end
      end
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH: state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_RST;
    endcase
  end

  // Datapath controls decoded from state; write enables and retire also watch mem_ready/zero.
  always_comb begin
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    iord_s       = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    alu_src_a_s  = SRC_A_PC;
    alu_src_b_s  = SRC_B_RS2;
    aluop_s      = ALUOP_ADD;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    retire_s     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_s   = 1'b1;
        alu_src_b_s = SRC_B_FOUR;
        ir_write_s  = bus.mem_ready;
        pc_write_s  = bus.mem_ready;
      end
      ST_DECODE: begin
        alu_src_a_s = SRC_A_OLDPC;
        alu_src_b_s = SRC_B_IMM;
      end
      ST_EXEC_R: begin
        alu_src_a_s = SRC_A_RS1;
        aluop_s     = ALUOP_FUNCT;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        alu_src_a_s = SRC_A_RS1;
        alu_src_b_s = SRC_B_IMM;
      end
      ST_MEM_RD: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        mem_we_s  = 1'b1;
        retire_s  = bus.mem_ready;
      end
      ST_WB_ALU: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      ST_WB_MEM: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        retire_s     = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_s = SRC_A_RS1;
        aluop_s     = ALUOP_BRANCH;
        pc_src_s    = 1'b1;
        pc_write_s  = bus.zero;
        retire_s    = 1'b1;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and sticky trap-cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign bus.mem_req    = mem_req_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.iord       = iord_s;
  assign bus.ir_write   = ir_write_s;
  assign bus.pc_write   = pc_write_s;
  assign bus.pc_src     = pc_src_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.aluop      = aluop_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.retire     = retire_s;
  assign bus.trap       = (state_q == ST_TRAP);
  assign bus.trap_cause = cause_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios followed by random instruction
// streams, each cycle compared against a per-instruction reference trace.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TMO = 4;

  typedef struct packed {
    logic        rdy;
    logic        z;
    logic [21:0] exp;
  } cyc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .MEM_TIMEOUT(TMO),
    .CNT_W      (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [21:0] obs_s;
  assign obs_s = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                  bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.aluop,
                  bus.reg_write, bus.mem_to_reg, bus.retire, bus.trap,
                  bus.trap_cause, bus.state_dbg};

  cyc_t  q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string step  = "init";

  function automatic logic [21:0] vec(state_e st, logic req, logic we, logic io,
                                      logic irw, logic pcw, logic pcs,
                                      logic [1:0] a, logic [1:0] b, logic [1:0] op,
                                      logic rw, logic m2r, logic ret, logic trp,
                                      logic [1:0] cause);
    logic [3:0] s;
    s = st;
    return {req, we, io, irw, pcw, pcs, a, b, op, rw, m2r, ret, trp, cause, s};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic rdy, input logic z, input logic [21:0] e);
    cyc_t c;
    c.rdy = rdy;
    c.z   = z;
    c.exp = e;
    q.push_back(c);
  endtask

  // One memory access of `waits` stall cycles; hitting TMO stalls ends in a trap.
  task automatic model_access(input state_e st, input int waits, output bit trapped);
    logic       f;
    logic       w;
    logic [1:0] b;
    f = (st == ST_FETCH);
    w = (st == ST_MEM_WR);
    b = f ? 2'b01 : 2'b00;
    trapped = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        add(1'b1, rb(), vec(st, 1'b1, w, !f, f, f, 1'b0, 2'b00, b, 2'b00,
                            1'b0, 1'b0, w, 1'b0, 2'b00));
        return;
      end
      add(1'b0, rb(), vec(st, 1'b1, w, !f, 1'b0, 1'b0, 1'b0, 2'b00, b, 2'b00,
                          1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
      if (i == TMO - 1) begin
        trapped = 1'b1;
        return;
      end
    end
  endtask

  task automatic model_trap(input logic [1:0] cause, input int n);
    for (int i = 0; i < n; i++) begin
      add(rb(), rb(), vec(ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                          2'b00, 1'b0, 1'b0, 1'b0, 1'b1, cause));
    end
  endtask

  task automatic model_instr(input logic [6:0] op, input logic z, input int fw,
                             input int mw, output bit trapped, output logic [1:0] cause);
    logic [21:0] wb_alu;
    logic [21:0] addr;
    cause  = 2'b00;
    wb_alu = vec(ST_WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    addr   = vec(ST_MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00,
                 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    model_access(ST_FETCH, fw, trapped);
    if (trapped) begin
      cause = 2'b10;
      return;
    end
    add(rb(), rb(), vec(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10,
                        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    if (op == 7'b0110011) begin
      add(rb(), rb(), vec(ST_EXEC_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00,
                          2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
      add(rb(), rb(), wb_alu);
    end else if (op == 7'b0010011) begin
      add(rb(), rb(), vec(ST_EXEC_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10,
                          2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
      add(rb(), rb(), wb_alu);
    end else if (op == 7'b0000011) begin
      add(rb(), rb(), addr);
      model_access(ST_MEM_RD, mw, trapped);
      if (trapped) begin
        cause = 2'b10;
        return;
      end
      add(rb(), rb(), vec(ST_WB_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                          2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00));
    end else if (op == 7'b0100011) begin
      add(rb(), rb(), addr);
      model_access(ST_MEM_WR, mw, trapped);
      if (trapped) begin
        cause = 2'b10;
      end
    end else if (op == 7'b1100011) begin
      add(rb(), z, vec(ST_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, z, 1'b1, 2'b01, 2'b00, 2'b01,
                       1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    end else begin
      trapped = 1'b1;
      cause   = 2'b01;
    end
  endtask

  // Plays up to n queued cycles, checking outputs mid-cycle; leftovers are dropped.
  task automatic run(input int n);
    cyc_t c;
    int   k;
    k = 0;
    while (q.size() > 0 && k < n) begin
      c = q.pop_front();
      bus.mem_ready = c.rdy;
      bus.zero      = c.z;
      @(negedge clk);
      n_vec++;
      assert (obs_s === c.exp)
      else begin
        n_err++;
        $error("FAIL %s cyc%0d: observed %h expected %h", step, k, obs_s, c.exp);
      end
      @(posedge clk);
      #1;
      k++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    logic [21:0] rst_vec;
    rst_vec = vec(ST_RST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    assert (obs_s === rst_vec)
    else begin
      n_err++;
      $error("FAIL reset_%s: observed %h expected %h", step, obs_s, rst_vec);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    add(rb(), rb(), rst_vec);
  endtask

  task automatic do_instr(input string name, input logic [6:0] op, input logic z,
                          input int fw, input int mw, input int trap_cycles);
    bit         tr;
    logic [1:0] cs;
    step       = name;
    bus.opcode = op;
    model_instr(op, z, fw, mw, tr, cs);
    if (tr) begin
      model_trap(cs, trap_cycles);
    end
    run(100000);
    if (tr) begin
      do_reset();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] op;
    int         r;
    int         fw;
    int         mw;
    bus.opcode    = OP_R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    do_reset();
    do_instr("rtype",     7'b0110011, 1'b0, 0, 0, 0);
    do_instr("load_w2",   7'b0000011, 1'b0, 0, 2, 0);
    do_instr("branch_z1", 7'b1100011, 1'b1, 0, 0, 0);
    do_instr("branch_z0", 7'b1100011, 1'b0, 0, 0, 0);
    do_instr("itype_f2",  7'b0010011, 1'b0, 2, 0, 0);
    do_instr("store_lim", 7'b0100011, 1'b0, 1, TMO - 1, 0);
    do_instr("fetch_lim", 7'b0010011, 1'b0, TMO - 1, 0, 0);
    do_instr("illegal",   7'b1111111, 1'b0, 0, 0, 20);
    do_instr("fetch_tmo", 7'b0110011, 1'b0, TMO, 0, 5);
    do_instr("load_tmo",  7'b0000011, 1'b0, 0, TMO, 3);

    // Reset asserted while a store is waiting in MEM_WR.
    step       = "rst_mid";
    bus.opcode = 7'b0100011;
    begin
      bit         tr;
      logic [1:0] cs;
      model_instr(7'b0100011, 1'b0, 0, TMO, tr, cs);
    end
    run(5);
    bus.mem_ready = 1'b0;
    #1;
    n_vec++;
    assert ({bus.mem_req, bus.mem_we} === 2'b11)
    else begin
      n_err++;
      $error("FAIL rst_mid_pre: observed %b expected %b", {bus.mem_req, bus.mem_we}, 2'b11);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    assert ({bus.mem_req, bus.mem_we} === 2'b00)
    else begin
      n_err++;
      $error("FAIL rst_mid_drop: observed %b expected %b", {bus.mem_req, bus.mem_we}, 2'b00);
    end
    do_reset();
    do_instr("after_rst", 7'b0110011, 1'b0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    op = OP_R;
        2, 3:    op = OP_I;
        4, 5:    op = OP_LOAD;
        6, 7:    op = OP_STORE;
        8:       op = OP_BRANCH;
        default: begin
          do begin
            op = 7'($urandom);
          end while (op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH});
        end
      endcase
      fw = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, TMO - 1);
      mw = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, TMO - 1);
      do_instr($sformatf("rand%0d", i), op, rb(), fw, mw, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath.
- Replaces the single-cycle decode: one shared instruction/data memory port, one ALU reused across phases.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives datapath mux selects, register enables and the memory handshake.
- Traps on illegal opcode or memory timeout.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before trapping (min 1).
- CNT_W, 5, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- opcode, input, 7, instruction register bits [6:0].
- zero, input, 1, ALU zero flag (rs1 == rs2 compare).
- mem_ready, input, 1, memory completes the current access this cycle.
- mem_req, output, 1, memory access request.
- mem_we, output, 1, write strobe, valid while mem_req.
- iord, output, 1, memory address select: 0=PC, 1=ALUOut.
- ir_write, output, 1, load instruction register.
- pc_write, output, 1, PC enable.
- pc_src, output, 1, next PC select: 0=ALU result, 1=ALUOut.
- alu_src_a, output, 2, ALU A select: 00=PC, 01=rs1, 10=oldPC.
- alu_src_b, output, 2, ALU B select: 00=rs2, 01=const 4, 10=imm.
- aluop, output, 2, to alu_control: 00=add, 01=branch compare, 10=funct decode.
- reg_write, output, 1, register file write enable.
- mem_to_reg, output, 1, writeback select: 0=ALUOut, 1=MDR.
- retire, output, 1, one-cycle pulse at instruction completion.
- trap, output, 1, sticky halt flag.
- trap_cause, output, 2, 01=illegal opcode, 10=memory timeout.
- state_dbg, output, 4, current state encoding.

Behaviour:
- Reset: async on rst_n low, state=RST. All outputs 0; trap_cause=00; wait counter=0.
- RST: outputs all 0. Always goes to FETCH next cycle.
- Outputs are decoded from state (Moore). Exceptions: pc_write and retire, which also depend on mem_ready/zero as noted below.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, aluop=00, pc_src=0.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - alu_src_a=10, alu_src_b=10, aluop=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - any other -> TRAP with cause 01
- EXEC_R: alu_src_a=01, alu_src_b=00, aluop=10. Next WB_ALU.
- EXEC_I: alu_src_a=01, alu_src_b=10, aluop=00. Next WB_ALU.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, aluop=00. Next MEM_RD for a load, MEM_WR for a store (opcode held stable by the IR).
- MEM_RD: mem_req=1, iord=1, mem_we=0. Waits for mem_ready, then WB_MEM.
- MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ready: retire=1, next FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0, retire=1. Next FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, retire=1. Next FETCH.
- BRANCH:
  - alu_src_a=01, alu_src_b=00, aluop=01, pc_src=1.
  - pc_write=zero, retire=1. Next FETCH.
- Latency with zero wait states: R/I=4 cycles, load=5, store=4, branch=3. Each mem_ready stall adds one cycle.
- Wait counter:
  - Clears on entry to any request state and on mem_ready.
  - Increments each cycle mem_req=1 && !mem_ready.
  - Reaching MEM_TIMEOUT without mem_ready -> TRAP with cause 10. No pc/ir/reg write that cycle.
- mem_ready in the same cycle the count reaches MEM_TIMEOUT: ready wins and the access completes normally.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- TRAP: all control outputs 0, trap=1, trap_cause held. Exit only via rst_n.
- Reset mid-access: mem_req drops asynchronously; no partial writes are signalled.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - state enum, 4-bit
  - ALU-src and aluop encodings, shared with alu_control
  - trap cause codes
- One sub-module, mem_wait_timer: wait counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset release, R-type 0110011, mem_ready tied 1 -> states RST,FETCH,DECODE,EXEC_R,WB_ALU. reg_write=1 only in WB_ALU; retire pulses once at cycle 4 after FETCH entry.
- Load 0000011 with 2 wait cycles in MEM_RD -> mem_req=1/iord=1 for 3 cycles, then WB_MEM with mem_to_reg=1. Total 7 cycles.
- Branch 1100011, zero=1 then zero=0 -> pc_write=1 with pc_src=1 in BRANCH for the first; pc_write=0 for the second. Both 3 cycles.
- Opcode 1111111 in DECODE -> TRAP: trap=1, trap_cause=01, mem_req stays 0 for 20 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 stalled cycles with cause 10; ir_write never asserted.
- rst_n low during MEM_WR -> mem_req/mem_we fall immediately. After release: RST then FETCH, trap=0.
